// File: rtl/mac_psum_writeback_if.sv
// Bundles the MAC result/partial-sum bus and the requantized output stream.
// master = MAC array / writer side, slave = mac_psum_writeback.
interface mac_psum_writeback_if #(
  parameter int LANES  = 120,
  parameter int RES_W  = 33,
  parameter int PSUM_W = 28,
  parameter int OUT_W  = 16,
  parameter int IDX_W  = 7
);
  logic [LANES*RES_W-1:0]  result;
  logic                    result_vld;
  logic [LANES*PSUM_W-1:0] partial_output;
  logic [OUT_W-1:0]        out_data;
  logic [IDX_W-1:0]        out_lane;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output result, result_vld, out_ready,
    input  partial_output, out_data, out_lane, out_valid
  );

  modport slave (
    input  result, result_vld, out_ready,
    output partial_output, out_data, out_lane, out_valid
  );
endinterface

// File: rtl/mac_psum_writeback.sv
// Accumulates saturated MAC partial sums over a group of passes, then
// requantizes and streams one lane per handshake to the feature-map writer.
module mac_psum_writeback #(
  parameter int LANES      = 120,
  parameter int RES_W      = 33,
  parameter int PSUM_W     = 28,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 12,
  parameter int IDX_W      = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           num_pass,
  input  logic                 relu_en,
  mac_psum_writeback_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic                 proto_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [PSUM_W-1:0]  psum_q [LANES];
  logic [PSUM_W-1:0]  psum_d [LANES];
  logic [7:0]         pass_cnt_q, pass_cnt_d;
  logic [7:0]         num_pass_q, num_pass_d;
  logic               relu_q, relu_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               proto_err_q, proto_err_d;
  logic               load_out;
  logic [PSUM_W:0]    sat_r;
  logic [OUT_W:0]     q_r;
  logic [7:0]         last_pass;

  // Both helpers return {clip_flag, value}.
  function automatic logic [PSUM_W:0] sat_psum(input logic [RES_W-1:0] x);
    logic [RES_W-PSUM_W:0] top;
    top = x[RES_W-1:PSUM_W-1];
    if (&top || ~|top) return {1'b0, x[PSUM_W-1:0]};
    else if (x[RES_W-1]) return {1'b1, 1'b1, {(PSUM_W-1){1'b0}}};
    else return {1'b1, 1'b0, {(PSUM_W-1){1'b1}}};
  endfunction

  function automatic logic [OUT_W:0] requant(input logic [PSUM_W-1:0] x, input logic relu);
    logic signed [PSUM_W-1:0] y;
    logic [PSUM_W-OUT_W:0]    top;
    y = $signed(x) >>> FRAC_SHIFT;
    if (relu && y[PSUM_W-1]) y = '0;
    top = y[PSUM_W-1:OUT_W-1];
    if (&top || ~|top) return {1'b0, y[OUT_W-1:0]};
    else if (y[PSUM_W-1]) return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  assign last_pass = (num_pass_q == 8'd0) ? 8'd0 : num_pass_q - 8'd1;

  always_comb begin
    state_d     = state_q;
    psum_d      = psum_q;
    pass_cnt_d  = pass_cnt_q;
    num_pass_d  = num_pass_q;
    relu_d      = relu_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    proto_err_d = proto_err_q;
    load_out    = 1'b0;
    sat_r       = '0;
    q_r         = '0;

    if (bus.result_vld && state_q != ACCUM) proto_err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ACCUM;
          pass_cnt_d = '0;
          ovf_d      = 1'b0;
          num_pass_d = num_pass;
          relu_d     = relu_en;
          for (int i = 0; i < LANES; i++) psum_d[i] = '0;
        end
      end
      ACCUM: begin
        if (bus.result_vld) begin
          for (int i = 0; i < LANES; i++) begin
            sat_r     = sat_psum(bus.result[i*RES_W +: RES_W]);
            psum_d[i] = sat_r[PSUM_W-1:0];
            if (sat_r[PSUM_W]) ovf_d = 1'b1;
          end
          pass_cnt_d = pass_cnt_q + 8'd1;
          if (pass_cnt_q == last_pass) begin
            state_d     = DRAIN;
            idx_d       = '0;
            out_valid_d = 1'b1;
            load_out    = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (idx_q == IDX_W'(LANES-1)) begin
            out_valid_d = 1'b0;
            state_d     = DONE;
          end else begin
            idx_d    = idx_q + 1'b1;
            load_out = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Requantize from psum_d so the first beat sees the pass that just landed.
    if (load_out) begin
      q_r        = requant(psum_d[idx_d], relu_q);
      out_data_d = q_r[OUT_W-1:0];
      if (q_r[OUT_W]) ovf_d = 1'b1;
    end

    busy_d = (state_d == ACCUM) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < LANES; i++) psum_q[i] <= '0;
      pass_cnt_q  <= '0;
      num_pass_q  <= '0;
      relu_q      <= 1'b0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < LANES; i++) psum_q[i] <= psum_d[i];
      pass_cnt_q  <= pass_cnt_d;
      num_pass_q  <= num_pass_d;
      relu_q      <= relu_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    bus.partial_output = '0;
    for (int i = 0; i < LANES; i++) bus.partial_output[i*PSUM_W +: PSUM_W] = psum_q[i];
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_lane  = idx_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign ovf           = ovf_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_mac_psum_writeback.sv
// Directed bench for mac_psum_writeback: a table of single-lane groups
// plus hand-written multi-pass, stall, misuse and mid-drain reset sequences.
module tb_mac_psum_writeback;

  localparam int LANES = 120;

  typedef struct {
    int          lane;
    logic [32:0] res;
    logic [7:0]  np;
    bit          relu;
    logic [27:0] exp_psum;
    logic [15:0] exp_out;
    bit          exp_ovf;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] num_pass;
  logic       relu_en;
  logic       busy;
  logic       done;
  logic       ovf;
  logic       proto_err;

  int total;
  int bad;

  logic [15:0] exp_out [LANES];
  vec_t        vecs [12];

  mac_psum_writeback_if bus ();

  mac_psum_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_pass  (num_pass),
    .relu_en   (relu_en),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got expired expected finish");
    $fatal(1, "[TB] global timeout");
  end

  function automatic logic [27:0] plane(input int i);
    return bus.partial_output[i*28 +: 28];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic startGroup(input logic [7:0] np, input bit relu);
    start    = 1'b1;
    num_pass = np;
    relu_en  = relu;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic sendResult(input logic [LANES*33-1:0] res);
    bus.result     = res;
    bus.result_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.result_vld = 1'b0;
  endtask

  task automatic drainGroup(input bit random_ready, input bit poke_start, input int abort_lane);
    int          exp_lane;
    int          cycles;
    bit          stalled;
    logic [15:0] held_data;
    logic [6:0]  held_lane;
    exp_lane = 0; cycles = 0; stalled = 0; held_data = '0; held_lane = '0;
    while (exp_lane < LANES) begin
      if (bus.out_valid !== 1'b1) begin
        checkOutput("drain_valid", {31'b0, bus.out_valid}, 32'd1);
        break;
      end
      if (cycles >= 2000) begin
        checkOutput("drain_timeout", 32'd1, 32'd0);
        break;
      end
      if (stalled) begin
        checkOutput("stall_data", {16'b0, bus.out_data}, {16'b0, held_data});
        checkOutput("stall_lane", {25'b0, bus.out_lane}, {25'b0, held_lane});
      end
      checkOutput("out_lane", {25'b0, bus.out_lane}, exp_lane);
      checkOutput("out_data", {16'b0, bus.out_data}, {16'b0, exp_out[exp_lane]});
      checkOutput("done_early", {31'b0, done}, 32'd0);
      if (exp_lane == abort_lane) begin
        rst = 1'b1;
        bus.out_ready = 1'b0;
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        return;
      end
      bus.out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = poke_start && (exp_lane < 10);
      held_data = bus.out_data;
      held_lane = bus.out_lane;
      @(posedge clk); @(negedge clk);
      cycles++;
      if (bus.out_ready) begin
        exp_lane++;
        stalled = 0;
      end else begin
        stalled = 1;
      end
    end
    start = 1'b0;
    bus.out_ready = 1'b0;
    if (exp_lane == LANES) begin
      checkOutput("valid_after_last", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("done_pulse", {31'b0, done}, 32'd1);
      @(negedge clk);
      checkOutput("done_one_cycle", {31'b0, done}, 32'd0);
      checkOutput("busy_idle", {31'b0, busy}, 32'd0);
    end
  endtask

  // One single-lane group from the vector table, all other lanes zero.
  task automatic applyStimulus(input vec_t v, input bit random_ready);
    logic [LANES*33-1:0] res;
    res = '0;
    res[v.lane*33 +: 33] = v.res;
    startGroup(v.np, v.relu);
    sendResult(res);
    checkOutput("psum_lane", {4'b0, plane(v.lane)}, {4'b0, v.exp_psum});
    checkOutput("psum_other", {4'b0, plane((v.lane + 1) % LANES)}, 32'd0);
    for (int i = 0; i < LANES; i++) exp_out[i] = '0;
    exp_out[v.lane] = v.exp_out;
    drainGroup(random_ready, 1'b0, -1);
    checkOutput("ovf_group", {31'b0, ovf}, {31'b0, v.exp_ovf});
    checkOutput("proto_err_clean", {31'b0, proto_err}, 32'd0);
  endtask

  task automatic checkResetState();
    checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_lane", {25'b0, bus.out_lane}, 32'd0);
    checkOutput("rst_out_data", {16'b0, bus.out_data}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_ovf", {31'b0, ovf}, 32'd0);
    checkOutput("rst_proto_err", {31'b0, proto_err}, 32'd0);
    checkOutput("rst_psum_any", {31'b0, |bus.partial_output}, 32'd0);
  endtask

  initial begin
    logic [LANES*33-1:0] res;
    logic [27:0]         p5;
    total = 0;
    bad   = 0;

    vecs[0]  = '{0,   33'h0_0000_5000, 8'd0, 1'b0, 28'h0005000, 16'h0005, 1'b0};
    vecs[1]  = '{1,   33'h1_FFFF_F000, 8'd1, 1'b0, 28'hFFFF000, 16'hFFFF, 1'b0};
    vecs[2]  = '{0,   33'h0_4000_0000, 8'd1, 1'b0, 28'h7FFFFFF, 16'h7FFF, 1'b1};
    vecs[3]  = '{1,   33'h1_C000_0000, 8'd1, 1'b0, 28'h8000000, 16'h8000, 1'b1};
    vecs[4]  = '{2,   33'h1_FFFF_E000, 8'd1, 1'b1, 28'hFFFE000, 16'h0000, 1'b0};
    vecs[5]  = '{119, 33'h0_07FF_FFFF, 8'd1, 1'b0, 28'h7FFFFFF, 16'h7FFF, 1'b0};
    vecs[6]  = '{118, 33'h1_F800_0000, 8'd1, 1'b0, 28'h8000000, 16'h8000, 1'b0};
    vecs[7]  = '{3,   33'h0_0800_0000, 8'd1, 1'b0, 28'h7FFFFFF, 16'h7FFF, 1'b1};
    vecs[8]  = '{4,   33'h0_0000_0FFF, 8'd1, 1'b0, 28'h0000FFF, 16'h0000, 1'b0};
    vecs[9]  = '{5,   33'h1_FFFF_FFFF, 8'd1, 1'b0, 28'hFFFFFFF, 16'hFFFF, 1'b0};
    vecs[10] = '{6,   33'h1_FFFF_FFFF, 8'd1, 1'b1, 28'hFFFFFFF, 16'h0000, 1'b0};
    vecs[11] = '{7,   33'h0_0000_3000, 8'd1, 1'b1, 28'h0003000, 16'h0003, 1'b0};

    rst = 1'b1; start = 1'b0; num_pass = '0; relu_en = 1'b0;
    bus.result = '0; bus.result_vld = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkResetState();

    for (int k = 0; k < 12; k++) applyStimulus(vecs[k], k[0]);

    // Two lanes in one group: lane0=5, lane1=-1.
    res = '0;
    res[0*33 +: 33] = 33'h0_0000_5000;
    res[1*33 +: 33] = 33'h1_FFFF_F000;
    startGroup(8'd1, 1'b0);
    sendResult(res);
    for (int i = 0; i < LANES; i++) exp_out[i] = '0;
    exp_out[0] = 16'h0005;
    exp_out[1] = 16'hFFFF;
    drainGroup(1'b0, 1'b0, -1);
    checkOutput("ovf_two_lane", {31'b0, ovf}, 32'd0);

    // Three passes; the bench adds the fed-back psum like the MAC would.
    startGroup(8'd3, 1'b0);
    checkOutput("psum_cleared_on_start", {4'b0, plane(0)}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      p5 = plane(5);
      res = '0;
      res[5*33 +: 33] = 33'($signed(p5)) + 33'd4096;
      sendResult(res);
      checkOutput("multipass_psum", {4'b0, plane(5)}, 32'(4096 * (k + 1)));
      if (k == 0) begin
        @(negedge clk);
        checkOutput("psum_stable_gap", {4'b0, plane(5)}, 32'd4096);
        checkOutput("busy_in_accum", {31'b0, busy}, 32'd1);
        checkOutput("no_early_drain", {31'b0, bus.out_valid}, 32'd0);
      end
    end
    for (int i = 0; i < LANES; i++) exp_out[i] = '0;
    exp_out[5] = 16'h0003;
    drainGroup(1'b1, 1'b0, -1);

    // start held during the first part of DRAIN must be ignored.
    res = '0;
    res[10*33 +: 33] = 33'h0_0000_7000;
    startGroup(8'd1, 1'b0);
    sendResult(res);
    for (int i = 0; i < LANES; i++) exp_out[i] = '0;
    exp_out[10] = 16'h0007;
    drainGroup(1'b0, 1'b1, -1);
    checkOutput("proto_err_before_misuse", {31'b0, proto_err}, 32'd0);

    // result_vld in IDLE: flagged and ignored.
    res = '0;
    for (int i = 0; i < LANES; i++) res[i*33 +: 33] = 33'h0_0000_1234;
    sendResult(res);
    checkOutput("proto_err_idle_vld", {31'b0, proto_err}, 32'd1);
    checkOutput("psum_kept_idle_vld", {4'b0, plane(10)}, 32'h7000);
    checkOutput("busy_idle_vld", {31'b0, busy}, 32'd0);

    // start and result_vld together in IDLE: start wins, result dropped.
    start = 1'b1; num_pass = 8'd1; relu_en = 1'b0;
    bus.result = res; bus.result_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; bus.result_vld = 1'b0;
    checkOutput("busy_start_with_vld", {31'b0, busy}, 32'd1);
    checkOutput("psum_cleared_vld_ignored", {4'b0, plane(10)}, 32'd0);

    // Finish this group but reset mid-drain at lane 60.
    res = '0;
    res[20*33 +: 33] = 33'h1_C000_0000;
    sendResult(res);
    for (int i = 0; i < LANES; i++) exp_out[i] = '0;
    exp_out[20] = 16'h8000;
    drainGroup(1'b0, 1'b0, 60);
    checkResetState();

    applyStimulus(vecs[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_psum_writeback.md
Name: mac_psum_writeback

Overview:
- Consumer end of the MAC array interface, and the source of its C operand.
- Captures the per-lane 33-bit `result` bus on each `result_vld` and saturates every lane to 28 bits. Holds these values as `partial_output` for the next MAC pass.
- After the programmed number of passes, requantizes the 120 lane sums (shift, optional ReLU, 16-bit saturation) and streams them out one lane per handshake to the feature-map buffer writer.

Parameters:
- LANES, 120, number of MAC lanes (matches MAC_NUM).
- RES_W, 33, MAC result width per lane.
- PSUM_W, 28, partial-sum width per lane.
- OUT_W, 16, output activation width.
- FRAC_SHIFT, 12, arithmetic right shift applied at requantization.
- IDX_W, 7, lane index width (must satisfy 2^IDX_W >= LANES).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin new accumulation group (sampled in IDLE only)
- num_pass  in  8  MAC passes per group; 0 treated as 1; sampled on accepted start
- relu_en  in  1  apply ReLU at requantization; sampled on accepted start
- result  in  LANES*RES_W  per-lane MAC results, lane i at [i*33 +: 33], signed
- result_vld  in  1  result bus valid this cycle
- partial_output  out  LANES*PSUM_W  registered per-lane partial sums, lane i at [i*28 +: 28]
- out_data  out  OUT_W  requantized activation, signed
- out_lane  out  IDX_W  lane index of out_data
- out_valid  out  1  out_data/out_lane valid
- out_ready  in  1  downstream accepts
- busy  out  1  high in ACCUM and DRAIN
- done  out  1  one-cycle pulse, group fully drained
- ovf  out  1  sticky: any 28-bit or 16-bit saturation event this group
- proto_err  out  1  sticky: result_vld seen outside ACCUM; cleared by rst only

Behaviour:
- Reset (synchronous, rst=1 at clk edge), any state including mid-group:
  - State returns to IDLE.
  - All psum registers, pass_cnt, out_data, out_lane, out_valid, busy, done, ovf and proto_err go to 0.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start=1 → ACCUM next cycle.
  - On the accepting edge: all psums <= 0 (so the first MAC pass sees C=0), pass_cnt <= 0, ovf <= 0, num_pass and relu_en latched.
- ACCUM:
  - Each result_vld cycle: every lane psum[i] <= sat28(result lane i); pass_cnt++.
  - sat28 rule: value > 2^27-1 → 2^27-1; value < -2^27 → -2^27 (0x8000000); otherwise low 28 bits unchanged. Any clip sets ovf.
  - partial_output reflects new psums the cycle after result_vld. It is stable between result_vld events.
  - On the result_vld where pass_cnt == eff_num_pass-1: go to DRAIN and set idx <= 0.
- DRAIN:
  - First cycle in DRAIN: out_valid=1, out_lane=0, out_data=q(psum[0]).
  - q(x) steps, in order:
    1. y = x >>> FRAC_SHIFT (arithmetic, truncation toward -inf).
    2. If relu_en and y<0, y=0.
    3. Saturate y to [-32768, 32767]; a clip sets ovf.
  - out_data and out_lane are registered. They hold stable while out_valid && !out_ready.
  - On out_valid && out_ready with idx < LANES-1: next cycle presents idx+1.
  - On the handshake with idx == LANES-1: out_valid <= 0 and go to DONE.
  - out_valid is never deasserted without a handshake, except by rst.
- DONE: done=1 for exactly one cycle, then IDLE. Psums are retained until the next accepted start.
- Ignored events:
  - start outside IDLE is ignored.
  - result_vld outside ACCUM is ignored, but sets proto_err.
  - start and result_vld in the same IDLE cycle: start is accepted, result_vld is ignored and sets proto_err.
- Throughput: back-to-back result_vld on consecutive cycles is supported in ACCUM. DRAIN sustains one lane per cycle with out_ready held high, so a full group drains in LANES cycles.

Test Plan:
- Reset then start with num_pass=1, relu_en=0; one result_vld with lane0=0x0_0000_5000 and lane1=-4096, all other lanes 0 → stream lane0=5, lane1=-1, rest 0; 120 beats, then done pulse; ovf=0.
- num_pass=3, lane5 result sequence 4096, 8192, 12288 (bench adds psum to emulate the MAC) → partial_output lane5 reads 4096 then 8192 after each vld; final lane5 out_data=3; done after the 120th handshake.
- Saturation:
  - lane0 result=2^30 → psum=0x7FFFFFF, ovf=1, out_data=32767.
  - lane1 result=-2^30 → psum=0x8000000, out_data=-32768.
- relu_en=1, lane2 result=-8192 → out_data=0 and ovf stays 0. Toggle out_ready randomly during DRAIN → out_data/out_lane stable while stalled, no lane skipped or duplicated.
- Misuse:
  - result_vld in IDLE → proto_err=1 and psums unchanged.
  - start asserted during DRAIN → ignored, drain completes normally.
- rst asserted at lane 60 of DRAIN → next cycle IDLE with all outputs 0; a fresh start then runs to completion correctly.
